ysyx_25020047_core_ctrl: RTL and testbench

//  Multi-cycle sequencer for the NPC datapath (IFU -> IDU/EXU -> LSU -> WBU). Drives instruction-fetch and

---
 rtl/ysyx_25020047_pkg.sv | 27 ++
 rtl/ysyx_25020047_wait_timer.sv | 23 ++
 rtl/ysyx_25020047_core_ctrl.sv | 131 +++++++++++++
 tb/tb_ysyx_25020047_core_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25020047_pkg.sv
// Shared state encoding and inst_type class masks for the NPC multi-cycle controller.
package ysyx_25020047_pkg;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    FWAIT = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    MWAIT = 3'd4,
    WB    = 3'd5,
    HALT  = 3'd6,
    ERR   = 3'd7
  } state_t;

  localparam logic [63:0] LOAD_MASK   = 64'h0000_00E0_0000_0060;
  localparam logic [63:0] STORE_MASK  = 64'h0000_0000_0020_0180;
  localparam logic [63:0] BRANCH_MASK = 64'h0000_0000_F000_C000;
  localparam logic [63:0] ECALL_MASK  = 64'h0000_0100_0000_0000;
  localparam logic [63:0] CSR_MASK    = 64'h0000_0600_0000_0000;
  localparam logic [63:0] EBREAK_MASK = 64'h0000_0800_0000_0000;
  localparam logic [63:0] NOWB_MASK   = STORE_MASK | BRANCH_MASK | ECALL_MASK | EBREAK_MASK;

  function automatic logic is_onehot64(input logic [63:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

endpackage

// File: rtl/ysyx_25020047_wait_timer.sv
// Response wait counter shared by the fetch and data wait phases; TIMEOUT=0 never expires.
module ysyx_25020047_wait_timer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign expired = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/ysyx_25020047_core_ctrl.sv
// Multi-cycle NPC sequencer: fetch/data handshakes, commit pulses, halt on ebreak, trap on error.
module ysyx_25020047_core_ctrl
  import ysyx_25020047_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] inst_type,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_resp_valid,
  output logic        inst_latch_en,
  output logic        lsu_req_valid,
  output logic        lsu_req_wen,
  input  logic        lsu_req_ready,
  input  logic        lsu_resp_valid,
  output logic        mem_latch_en,
  output logic        pc_we,
  output logic        rf_we,
  output logic        csr_we,
  output logic        trap_we,
  output logic        commit,
  output logic        halt,
  output logic        error,
  output logic [2:0]  state_o
);

  state_t state, state_next;
  logic   timer_clear, timer_en, timer_expired;
  logic   is_load, is_store, is_nowb, is_csr, is_ecall, is_ebreak, legal;

  assign is_load   = |(inst_type & LOAD_MASK);
  assign is_store  = |(inst_type & STORE_MASK);
  assign is_nowb   = |(inst_type & NOWB_MASK);
  assign is_csr    = |(inst_type & CSR_MASK);
  assign is_ecall  = |(inst_type & ECALL_MASK);
  assign is_ebreak = |(inst_type & EBREAK_MASK);
  assign legal     = is_onehot64(inst_type);

  ysyx_25020047_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    ifu_req_valid = 1'b0;
    inst_latch_en = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_wen   = 1'b0;
    mem_latch_en  = 1'b0;
    pc_we         = 1'b0;
    rf_we         = 1'b0;
    csr_we        = 1'b0;
    trap_we       = 1'b0;
    commit        = 1'b0;
    halt          = 1'b0;
    error         = 1'b0;
    timer_clear   = 1'b0;
    timer_en      = 1'b0;
    unique case (state)
      FETCH: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) begin
          state_next  = FWAIT;
          timer_clear = 1'b1;
        end
      end
      // A response in the expiry cycle still wins over the timeout.
      FWAIT: begin
        if (ifu_resp_valid) begin
          inst_latch_en = 1'b1;
          state_next    = EXEC;
        end else if (timer_expired) begin
          state_next = ERR;
        end else begin
          timer_en = 1'b1;
        end
      end
      EXEC: begin
        if (!legal)                    state_next = ERR;
        else if (is_load || is_store)  state_next = MEM;
        else                           state_next = WB;
      end
      MEM: begin
        lsu_req_valid = 1'b1;
        lsu_req_wen   = is_store;
        if (lsu_req_ready) begin
          state_next  = MWAIT;
          timer_clear = 1'b1;
        end
      end
      MWAIT: begin
        if (lsu_resp_valid) begin
          mem_latch_en = is_load;
          state_next   = WB;
        end else if (timer_expired) begin
          state_next = ERR;
        end else begin
          timer_en = 1'b1;
        end
      end
      WB: begin
        commit     = 1'b1;
        pc_we      = 1'b1;
        rf_we      = !is_nowb;
        csr_we     = is_csr;
        trap_we    = is_ecall;
        state_next = is_ebreak ? HALT : FETCH;
      end
      HALT: halt  = 1'b1;
      ERR:  error = 1'b1;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_ysyx_25020047_core_ctrl.sv
// Directed bench for the NPC controller: per-cycle state/pulse checks with hand-computed expectations.
module tb_ysyx_25020047_core_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] inst_type = '0;
  logic        ifu_req_ready = 1'b0, ifu_resp_valid = 1'b0;
  logic        lsu_req_ready = 1'b0, lsu_resp_valid = 1'b0;
  logic        ifu_req_valid, inst_latch_en, lsu_req_valid, lsu_req_wen, mem_latch_en;
  logic        pc_we, rf_we, csr_we, trap_we, commit, halt, error;
  logic [2:0]  state_o;

  int checks = 0;
  int failures = 0;

  ysyx_25020047_core_ctrl #(
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .inst_type      (inst_type),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_resp_valid (ifu_resp_valid),
    .inst_latch_en  (inst_latch_en),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_resp_valid (lsu_resp_valid),
    .mem_latch_en   (mem_latch_en),
    .pc_we          (pc_we),
    .rf_we          (rf_we),
    .csr_we         (csr_we),
    .trap_we        (trap_we),
    .commit         (commit),
    .halt           (halt),
    .error          (error),
    .state_o        (state_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b0;
    lsu_req_ready = 1'b0; lsu_resp_valid = 1'b0;
    tick();
    tick();
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_pulses", 64'({inst_latch_en, mem_latch_en, pc_we, rf_we, csr_we, trap_we, commit}), 64'd0);
    check("rst_sticky", 64'({halt, error}), 64'd0);
    check("rst_ifu_req", 64'(ifu_req_valid), 64'd1);
    reset = 1'b0;
    #1;
  endtask

  // Runs one instruction from FETCH; lat = idle cycles before the data response.
  task automatic do_inst(input string nm, input logic [63:0] it, input bit mem, input bit wen,
                         input int lat, input bit exp_rf, input bit exp_csr, input bit exp_trap,
                         input bit exp_halt, input int exp_cpi);
    int cyc = 0;
    inst_type = it;
    ifu_req_ready = 1'b1;
    ifu_resp_valid = 1'b1;
    #1;
    check({nm, "_fetch"}, 64'({state_o, ifu_req_valid, inst_latch_en}), 64'({3'd0, 1'b1, 1'b0}));
    tick(); cyc++;
    ifu_req_ready = 1'b0;
    #1;
    check({nm, "_fwait"}, 64'({state_o, inst_latch_en, ifu_req_valid}), 64'({3'd1, 1'b1, 1'b0}));
    tick(); cyc++;
    ifu_resp_valid = 1'b0;
    #1;
    check({nm, "_exec"}, 64'({state_o, commit, pc_we}), 64'({3'd2, 1'b0, 1'b0}));
    tick(); cyc++;
    if (mem) begin
      lsu_req_ready = 1'b1;
      #1;
      check({nm, "_mem"}, 64'({state_o, lsu_req_valid, lsu_req_wen}), 64'({3'd3, 1'b1, wen}));
      tick(); cyc++;
      lsu_req_ready = 1'b0;
      for (int i = 0; i < lat; i++) begin
        #1;
        check({nm, "_mwait_idle"}, 64'({state_o, mem_latch_en}), 64'({3'd4, 1'b0}));
        tick(); cyc++;
      end
      lsu_resp_valid = 1'b1;
      #1;
      check({nm, "_mwait_resp"}, 64'({state_o, mem_latch_en}), 64'({3'd4, !wen}));
      tick(); cyc++;
      lsu_resp_valid = 1'b0;
    end
    #1;
    check({nm, "_wb_state"}, 64'(state_o), 64'd5);
    check({nm, "_wb_pulses"}, 64'({commit, pc_we, rf_we, csr_we, trap_we}),
          64'({1'b1, 1'b1, exp_rf, exp_csr, exp_trap}));
    tick(); cyc++;
    check({nm, "_cpi"}, 64'(cyc), 64'(exp_cpi));
    check({nm, "_post"}, 64'({state_o, commit, pc_we, rf_we, halt}),
          64'({exp_halt ? 3'd6 : 3'd0, 1'b0, 1'b0, 1'b0, exp_halt}));
  endtask

  initial begin
    do_reset();

    do_inst("addi",  64'h1,                   0, 0, 0, 1, 0, 0, 0, 4);
    do_inst("lw",    64'h20,                  1, 0, 3, 1, 0, 0, 0, 9);
    do_inst("sw",    64'h80,                  1, 1, 0, 0, 0, 0, 0, 6);
    do_inst("beq",   64'h4000,                0, 0, 0, 0, 0, 0, 0, 4);
    do_inst("ecall", 64'h0000_0100_0000_0000, 0, 0, 0, 0, 0, 1, 0, 4);
    do_inst("csrrw", 64'h0000_0200_0000_0000, 0, 0, 0, 1, 1, 0, 0, 4);
    do_inst("ebreak",64'h0000_0800_0000_0000, 0, 0, 0, 0, 0, 0, 1, 4);

    ifu_req_ready = 1'b1;
    tick();
    check("halt_absorb", 64'({state_o, halt, ifu_req_valid, lsu_req_valid}), 64'({3'd6, 1'b1, 1'b0, 1'b0}));
    do_reset();

    // illegal (non-one-hot) class
    inst_type = 64'h3;
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b1;
    tick();
    ifu_resp_valid = 1'b0;
    check("ill_exec", 64'(state_o), 64'd2);
    tick();
    check("ill_err", 64'({state_o, error}), 64'({3'd7, 1'b1}));
    ifu_req_ready = 1'b1;
    tick(); tick();
    check("ill_sticky", 64'({state_o, error, ifu_req_valid, commit}), 64'({3'd7, 1'b1, 1'b0, 1'b0}));
    do_reset();
    check("ill_recover", 64'({state_o, error, ifu_req_valid}), 64'({3'd0, 1'b0, 1'b1}));

    // zero class is illegal too
    inst_type = 64'h0;
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b1;
    tick();
    ifu_resp_valid = 1'b0;
    tick();
    check("zero_err", 64'({state_o, error}), 64'({3'd7, 1'b1}));
    do_reset();

    // fetch timeout, TIMEOUT=4
    inst_type = 64'h1;
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check("to_fwait", 64'({state_o, error}), 64'({3'd1, 1'b0}));
      tick();
    end
    check("to_err", 64'({state_o, error}), 64'({3'd7, 1'b1}));
    do_reset();

    // response in the expiry cycle wins
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    ifu_resp_valid = 1'b1;
    #1;
    check("to_edge_latch", 64'({state_o, inst_latch_en}), 64'({3'd1, 1'b1}));
    tick();
    ifu_resp_valid = 1'b0;
    check("to_edge_exec", 64'({state_o, error}), 64'({3'd2, 1'b0}));

    // data-side timeout on a load
    inst_type = 64'h20;
    tick();
    lsu_req_ready = 1'b1;
    tick();
    lsu_req_ready = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    check("mto_err", 64'({state_o, error, mem_latch_en}), 64'({3'd7, 1'b1, 1'b0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
